// File: rtl/rv32i_exec_unit.sv
// RV32I execute-stage block: immediate decoder, integer ALU and branch comparator.
// Optional macro EXEC_PIPE_OUT_EN registers result/take_b (1-cycle latency); imm stays combinational.
module rv32i_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] result,
  output logic            take_b
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;
  logic            br_take;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign shamt  = in_b[4:0];

  always_comb begin
    imm = '0;
    case (opcode)
      OP_I, OP_LOAD, OP_JALR, OP_SYSTEM:
        imm = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {inst[31:12], 12'b0};
      OP_JAL:
        imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

  // Non-ALU opcodes fall through to a plain add (PC+4, PC+imm, addresses).
  always_comb begin
    alu_res = in_a + in_b;
    if (opcode == OP_R || opcode == OP_I) begin
      case (funct3)
        3'b000:  alu_res = (opcode == OP_R && inst[30]) ? in_a - in_b : in_a + in_b;
        3'b001:  alu_res = in_a << shamt;
        3'b010:  alu_res = {31'b0, $signed(in_a) < $signed(in_b)};
        3'b011:  alu_res = {31'b0, in_a < in_b};
        3'b100:  alu_res = in_a ^ in_b;
        3'b101:  alu_res = inst[30] ? $unsigned($signed(in_a) >>> shamt) : in_a >> shamt;
        3'b110:  alu_res = in_a | in_b;
        default: alu_res = in_a & in_b;
      endcase
    end
  end

  always_comb begin
    br_take = 1'b0;
    if (opcode == OP_BRANCH) begin
      case (funct3)
        3'b000:  br_take = (in_a == in_b);
        3'b001:  br_take = (in_a != in_b);
        3'b100:  br_take = ($signed(in_a) < $signed(in_b));
        3'b101:  br_take = ($signed(in_a) >= $signed(in_b));
        3'b110:  br_take = (in_a < in_b);
        3'b111:  br_take = (in_a >= in_b);
        default: br_take = 1'b0;
      endcase
    end
  end

`ifdef EXEC_PIPE_OUT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      result <= '0;
      take_b <= 1'b0;
    end else begin
      result <= alu_res;
      take_b <= br_take;
    end
  end
`else
  // Clock and reset only matter for the registered-output build.
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ resetn;
  assign result = alu_res;
  assign take_b = br_take;
`endif

endmodule

// File: tb/tb_rv32i_exec_unit.sv
// Self-checking bench for rv32i_exec_unit: directed vectors plus randomized stimulus vs a reference model.
// Works for both the combinational build and the EXEC_PIPE_OUT_EN registered build.
module tb_rv32i_exec_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] inst, in_a, in_b;
  logic [31:0] imm, result;
  logic        take_b;

  int compared   = 0;
  int mismatched = 0;

  rv32i_exec_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .resetn(resetn),
    .inst  (inst),
    .in_a  (in_a),
    .in_b  (in_b),
    .imm   (imm),
    .result(result),
    .take_b(take_b)
  );

  always #5 clk = ~clk;

  // Reference model, derived from the ISA field definitions.
  function automatic logic [31:0] refImm(input logic [31:0] i);
    logic [11:0] f12;
    logic [12:0] f13;
    logic [20:0] f21;
    int v;
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        f12 = i[31:20];
        v = $signed(f12);
      end
      7'b0100011: begin
        f12 = {i[31:25], i[11:7]};
        v = $signed(f12);
      end
      7'b1100011: begin
        f13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        v = $signed(f13);
      end
      7'b0110111, 7'b0010111: v = i & 32'hFFFFF000;
      7'b1101111: begin
        f21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        v = $signed(f21);
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] refResult(input logic [31:0] i, input logic [31:0] a,
                                            input logic [31:0] b);
    int sh;
    logic [31:0] r;
    sh = b % 32;
    if (i[6:0] != 7'b0110011 && i[6:0] != 7'b0010011) return a + b;
    case (i[14:12])
      3'd0: r = (i[6:0] == 7'b0110011 && i[30]) ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd3: r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        r = a >> sh;
        if (i[30] && a[31]) r = r | ~(32'hFFFFFFFF >> sh);
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic refTake(input logic [31:0] i, input logic [31:0] a,
                                   input logic [31:0] b);
    if (i[6:0] != 7'b1100011) return 1'b0;
    case (i[14:12])
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) < int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return longint'(a) < longint'(b);
      3'd7: return longint'(a) >= longint'(b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, hold across one rising edge, sample 1 ns later.
  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    inst = i;
    in_a = a;
    in_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic runVector(input string tag, input logic [31:0] i, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_imm,
                           input logic [31:0] exp_res, input logic exp_take);
    applyStimulus(i, a, b);
    checkOutput({tag, "_imm"}, imm, exp_imm);
    checkOutput({tag, "_res"}, result, exp_res);
    checkOutput({tag, "_take"}, {31'b0, take_b}, {31'b0, exp_take});
  endtask

  task automatic resetPulse(input string tag, input logic [31:0] i, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_res,
                            input logic exp_take);
    applyStimulus(i, a, b);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
`ifdef EXEC_PIPE_OUT_EN
    checkOutput({tag, "_rst_res"}, result, 32'd0);
    checkOutput({tag, "_rst_take"}, {31'b0, take_b}, 32'd0);
`else
    checkOutput({tag, "_rst_res"}, result, exp_res);
    checkOutput({tag, "_rst_take"}, {31'b0, take_b}, {31'b0, exp_take});
`endif
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, "_rel_res"}, result, exp_res);
    checkOutput({tag, "_rel_take"}, {31'b0, take_b}, {31'b0, exp_take});
  endtask

  logic [6:0] ops[10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
                          7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};

  initial begin
    logic [31:0] r_inst, r_a, r_b, rnd;
    logic [6:0]  r_op;

    resetn = 1'b0;
    inst   = 32'd0;
    in_a   = 32'd0;
    in_b   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_res", result, 32'd0);
    checkOutput("reset_take", {31'b0, take_b}, 32'd0);
    checkOutput("reset_imm", imm, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    runVector("add",   32'h00208033, 32'd5,        32'd7,        32'd0,        32'd12,       1'b0);
    runVector("sub",   32'h40208033, 32'd5,        32'd7,        32'd0,        32'hFFFFFFFE, 1'b0);
    runVector("srai",  32'h4041D093, 32'h80000000, 32'd4,        32'h00000404, 32'hF8000000, 1'b0);
    runVector("srli",  32'h0041D093, 32'h80000000, 32'd4,        32'h00000004, 32'h08000000, 1'b0);
    runVector("slt",   32'h0020A033, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd1,        1'b0);
    runVector("sltu",  32'h0020B033, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        1'b0);
    runVector("sll31", 32'h00209033, 32'd1,        32'd31,       32'd0,        32'h80000000, 1'b0);
    runVector("sll0",  32'h00209033, 32'd1,        32'hFFFFFFE0, 32'd0,        32'd1,        1'b0);
    runVector("addi",  32'hFFF00093, 32'd10,       32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9,        1'b0);
    runVector("lui",   32'h123450B7, 32'd0,        32'h12345000, 32'h12345000, 32'h12345000, 1'b0);
    runVector("jal",   32'hFFDFF0EF, 32'h100,      32'd4,        32'hFFFFFFFC, 32'h104,      1'b0);
    runVector("sw",    32'h00112423, 32'h1000,     32'd8,        32'd8,        32'h1008,     1'b0);
    runVector("load",  32'h00002083, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        1'b0);
    runVector("blt",   32'h0020C063, 32'hFFFFFFFE, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b1);
    runVector("bge",   32'h0020D063, 32'hFFFFFFFE, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0);
    runVector("bltu",  32'h0020E063, 32'hFFFFFFFE, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0);
    runVector("bgeu",  32'h0020F063, 32'hFFFFFFFE, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b1);
    runVector("beq",   32'h00208063, 32'd3,        32'd3,        32'd0,        32'd6,        1'b1);
    runVector("bne",   32'h00209063, 32'd3,        32'd3,        32'd0,        32'd6,        1'b0);
    runVector("bf010", 32'h0020A063, 32'd3,        32'd3,        32'd0,        32'd6,        1'b0);
    runVector("addeq", 32'h00208033, 32'd3,        32'd3,        32'd0,        32'd6,        1'b0);

    // Latency: new inputs must not reach result before the next rising edge when registered.
    runVector("lat_add", 32'h00208033, 32'd5, 32'd7, 32'd0, 32'd12, 1'b0);
    @(negedge clk);
    inst = 32'h40208033;
    #1;
`ifdef EXEC_PIPE_OUT_EN
    checkOutput("lat_hold", result, 32'd12);
`else
    checkOutput("lat_hold", result, 32'hFFFFFFFE);
`endif
    @(posedge clk);
    #1;
    checkOutput("lat_next", result, 32'hFFFFFFFE);

    resetPulse("rst_add", 32'h00208033, 32'd5, 32'd7, 32'd12, 1'b0);
    resetPulse("rst_beq", 32'h00208063, 32'd3, 32'd3, 32'd6,  1'b1);

    for (int n = 0; n < 300; n++) begin
      rnd = $urandom();
      r_op = (n % 12 == 11) ? rnd[6:0] : ops[$urandom_range(0, 9)];
      r_inst = {rnd[31:7], r_op};
      r_a = $urandom();
      r_b = ($urandom_range(0, 3) == 0) ? r_a : $urandom();
      if ($urandom_range(0, 3) == 0) r_b = {27'b0, 5'($urandom_range(0, 31))};
      applyStimulus(r_inst, r_a, r_b);
      checkOutput($sformatf("rand%0d_imm", n), imm, refImm(r_inst));
      checkOutput($sformatf("rand%0d_res", n), result, refResult(r_inst, r_a, r_b));
      checkOutput($sformatf("rand%0d_take", n), {31'b0, take_b},
                  {31'b0, refTake(r_inst, r_a, r_b)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
